// File: rtl/clk_div_meter.sv
// clk_div_meter: measures high time and period of a divided clock in clk
// cycles and reports each result over a valid/ready handshake.
// Ports: clk, rst (sync, active-low), div_in, en, meas_ready in;
//        meas_valid, period, high_cycles, timeout, busy out.
// Optional macro CLK_DIV_METER_CHECK_EN adds exp_period in and mismatch out.
module clk_div_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535,
  parameter int TOL     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  input  logic             en,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cycles,
  output logic             timeout,
  output logic             busy
`ifdef CLK_DIV_METER_CHECK_EN
  ,
  input  logic [CNT_W-1:0] exp_period,
  output logic             mismatch
`endif
);

  if (TIMEOUT < 2 ||
      longint'(TIMEOUT) > ((longint'(1) << CNT_W) - 1) ||
      TOL < 0) begin : g_param_chk
    $error("clk_div_meter: TIMEOUT or TOL out of range");
  end

  localparam logic [CNT_W-1:0] LP_TO = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_HIGH,
    S_LOW,
    S_REPORT
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic             r_s1, r_s2, r_s3;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [CNT_W-1:0] r_high_tmp;
  logic [CNT_W-1:0] w_high_tmp_nx;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_timeout;
  logic             r_valid;
  logic             r_busy;
  logic             w_rise;
  logic             w_fall;
  logic             w_to;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_load;
  logic [CNT_W-1:0] w_ld_period;
  logic [CNT_W-1:0] w_ld_high;
  logic             w_ld_to;

  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;
  assign w_to   = (r_cnt == LP_TO);
  // Saturate at TIMEOUT so an edge that lands exactly on the limit
  // cannot push the counter past it and let it wrap.
  assign w_cnt_inc = w_to ? r_cnt : r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_high_tmp_nx = r_high_tmp;
    w_load        = 1'b0;
    w_ld_period   = '0;
    w_ld_high     = '0;
    w_ld_to       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        if (en) w_state_nx = S_ARM;
      end
      S_ARM: begin
        if (!en) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else if (w_rise) begin
          w_state_nx = S_HIGH;
          w_cnt_nx   = CNT_W'(1);
        end else if (w_to) begin
          w_state_nx = S_REPORT;
          w_cnt_nx   = '0;
          w_load     = 1'b1;
          w_ld_to    = 1'b1;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      S_HIGH: begin
        if (!en) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else if (w_fall) begin
          w_state_nx    = S_LOW;
          w_high_tmp_nx = r_cnt;
          w_cnt_nx      = w_cnt_inc;
        end else if (w_to) begin
          w_state_nx = S_REPORT;
          w_cnt_nx   = '0;
          w_load     = 1'b1;
          w_ld_to    = 1'b1;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      S_LOW: begin
        if (!en) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else if (w_rise) begin
          w_state_nx  = S_REPORT;
          w_cnt_nx    = '0;
          w_load      = 1'b1;
          w_ld_period = r_cnt;
          w_ld_high   = r_high_tmp;
        end else if (w_to) begin
          w_state_nx = S_REPORT;
          w_cnt_nx   = '0;
          w_load     = 1'b1;
          w_ld_to    = 1'b1;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      S_REPORT: begin
        w_cnt_nx = '0;
        if (meas_ready) w_state_nx = en ? S_ARM : S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

`ifdef CLK_DIV_METER_CHECK_EN
  localparam logic [CNT_W:0] LP_TOL = (CNT_W+1)'(TOL);

  logic [CNT_W:0] w_diff;
  logic [CNT_W:0] w_abs;
  logic           w_mm;
  logic           r_mm;

  always_comb begin
    w_diff = {1'b0, w_ld_period} - {1'b0, exp_period};
    w_abs  = w_diff[CNT_W] ? (~w_diff + (CNT_W+1)'(1)) : w_diff;
    w_mm   = w_ld_to | (w_abs > LP_TOL);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mm <= 1'b0;
    end else if (w_load) begin
      r_mm <= w_mm;
    end
  end

  assign mismatch = r_mm;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      r_cnt      <= '0;
      r_high_tmp <= '0;
      r_period   <= '0;
      r_high     <= '0;
      r_timeout  <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_s1       <= div_in;
      r_s2       <= r_s1;
      r_s3       <= r_s2;
      r_cnt      <= w_cnt_nx;
      r_high_tmp <= w_high_tmp_nx;
      r_valid    <= (w_state_nx == S_REPORT);
      r_busy     <= (w_state_nx != S_IDLE);
      if (w_load) begin
        r_period  <= w_ld_period;
        r_high    <= w_ld_high;
        r_timeout <= w_ld_to;
      end
    end
  end

  assign meas_valid  = r_valid;
  assign period      = r_period;
  assign high_cycles = r_high;
  assign timeout     = r_timeout;
  assign busy        = r_busy;

endmodule
